// File: rtl/simple_spi_slave_pkg.sv
// -----------------------------------------------------------------------------
// simple_spi_slave_pkg
//   Definitions shared by the SPI slave core and its pin synchronizer:
//   FSM state encoding, settings register offsets, config field positions,
//   and a helper that turns the num_bits field into a frame length.
// -----------------------------------------------------------------------------
package simple_spi_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Settings register offsets relative to BASE.
  localparam logic [7:0] REG_CFG    = 8'd0;
  localparam logic [7:0] REG_TXDATA = 8'd1;

  // Config word field positions.
  localparam int CFG_NUM_BITS_LSB = 0;
  localparam int CFG_NUM_BITS_W   = 6;
  localparam int CFG_RX_EDGE_BIT  = 30;
  localparam int CFG_TX_EDGE_BIT  = 31;

  // Edge bits give the sclk level after the edge of interest.
  typedef struct packed {
    logic       tx_edge;
    logic       rx_edge;
    logic [5:0] num_bits;
  } cfg_t;

  // A num_bits field of 0 encodes a full 32-bit frame.
  function automatic logic [5:0] frame_len(input logic [5:0] num_bits);
    return (num_bits == 6'd0) ? 6'd32 : num_bits;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// -----------------------------------------------------------------------------
// spi_pin_sync
//   Brings one asynchronous SPI pin into the clock domain through a 2-flop
//   synchronizer. With SIMPLE_SPI_SLAVE_GLITCH_FILTER_EN defined, the output
//   only follows the synchronized value once two consecutive synchronized
//   samples agree, which adds one clock of latency and swallows 1-cycle pulses.
//
// Ports
//   clock     system clock
//   reset     synchronous, active-high
//   pin       asynchronous pin input
//   sync      synchronized (optionally filtered) pin level
// Parameters
//   RESET_VAL level every stage takes during reset
// -----------------------------------------------------------------------------
module spi_pin_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic sync
);

  logic [1:0] meta;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) meta <= {2{RESET_VAL}};
    else       meta <= {meta[0], pin};
  end

`ifdef SIMPLE_SPI_SLAVE_GLITCH_FILTER_EN
  logic prev;
  logic held;

  // Follow the synchronized level only when it matches the previous sample;
  // otherwise keep presenting the last accepted level.
  assign sync = (meta[1] == prev) ? prev : held;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev <= RESET_VAL;
      held <= RESET_VAL;
    end else begin
      prev <= meta[1];
      held <= sync;
    end
  end
`else
  assign sync = meta[1];
`endif

endmodule

// File: rtl/simple_spi_slave.sv
// -----------------------------------------------------------------------------
// simple_spi_slave
//   Settings-bus controlled SPI slave. The external master's sen/sclk/mosi are
//   oversampled on the system clock; MOSI is shifted into a receive register
//   and a host-loaded word is shifted out on MISO. Each completed word updates
//   readback and pulses rx_stb; losing sen mid-word pulses abort_stb.
//
//   Optional build macro: SIMPLE_SPI_SLAVE_GLITCH_FILTER_EN (sclk/sen/mosi
//   glitch filter inside spi_pin_sync).
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   set_stb/addr/data       settings bus (BASE+0 config, BASE+1 tx data)
//   readback                last completed receive word
//   rx_stb                  one-cycle pulse when readback updates
//   abort_stb               one-cycle pulse when sen drops mid-word
//   tx_ready                transmit holding register is empty
//   sen, sclk, mosi         asynchronous SPI pins from the master
//   miso                    SPI data out, 0 when not selected
//   debug                   {state, sen_s, sclk_s, mosi_s, miso, bit_counter, 0}
// -----------------------------------------------------------------------------
module simple_spi_slave
  import simple_spi_slave_pkg::*;
#(
  parameter int   BASE     = 0,
  parameter logic CLK_IDLE = 1'b0,
  parameter logic SEN_IDLE = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  output logic [31:0] readback,
  output logic        rx_stb,
  output logic        abort_stb,
  output logic        tx_ready,
  input  logic        sen,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic [31:0] debug
);

  localparam logic [7:0] BASE_ADDR = BASE[7:0];

  // ---------------------------------------------------------------------------
  // Pin synchronizers. sen resets to its active level so a master still
  // selecting us across reset is not mistaken for a fresh select.
  // ---------------------------------------------------------------------------
  logic sen_s, sclk_s, mosi_s;

  spi_pin_sync #(.RESET_VAL(~SEN_IDLE)) u_sync_sen (
    .clock (clock), .reset (reset), .pin (sen),  .sync (sen_s)
  );
  spi_pin_sync #(.RESET_VAL(CLK_IDLE)) u_sync_sclk (
    .clock (clock), .reset (reset), .pin (sclk), .sync (sclk_s)
  );
  spi_pin_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clock (clock), .reset (reset), .pin (mosi), .sync (mosi_s)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic        sclk_q, sen_q;
  cfg_t        cfg_q;          // host-written config
  cfg_t        cfg_act;        // config captured at select
  logic [31:0] tx_hold;
  logic        tx_ready_q;
  logic [31:0] tx_shift, rx_shift;
  logic [5:0]  bit_cnt;
  logic        tx_skip;        // suppress the first leading-edge tx shift
  logic [31:0] readback_q;
  logic        rx_stb_q, abort_stb_q;

  // ---------------------------------------------------------------------------
  // Edge / event decode
  // ---------------------------------------------------------------------------
  logic        sclk_edge, rx_edge, tx_edge, select, sen_off, last_bit;
  logic [31:0] rx_shift_next;
  logic [5:0]  bit_cnt_next;
  logic        cfg_wr, tx_wr;

  assign sclk_edge     = (sclk_s != sclk_q);
  assign rx_edge       = sclk_edge && (sclk_s == cfg_act.rx_edge);
  assign tx_edge       = sclk_edge && (sclk_s == cfg_act.tx_edge);
  assign select        = (sen_q == SEN_IDLE) && (sen_s != SEN_IDLE);
  assign sen_off       = (sen_s == SEN_IDLE);
  assign rx_shift_next = {rx_shift[30:0], mosi_s};
  assign bit_cnt_next  = bit_cnt + 6'd1;
  assign last_bit      = rx_edge && (bit_cnt_next == frame_len(cfg_act.num_bits));
  assign cfg_wr        = set_stb && (set_addr == BASE_ADDR + REG_CFG);
  assign tx_wr         = set_stb && (set_addr == BASE_ADDR + REG_TXDATA);

  // Config bits outside the decoded fields are reserved.
  logic unused_set_data;
  assign unused_set_data = ^set_data[29:6];

  // ---------------------------------------------------------------------------
  // FSM next state and strobes
  // ---------------------------------------------------------------------------
  logic do_select, do_finish, do_abort;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    do_select = 1'b0;
    do_finish = 1'b0;
    do_abort  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (select) begin
          state_d   = ST_SHIFT;
          do_select = 1'b1;
        end
      end
      ST_SHIFT: begin
        // Deselect wins over a coinciding last edge, so the two strobes
        // can never fire together.
        if (sen_off) begin
          state_d  = ST_IDLE;
          do_abort = 1'b1;
        end else if (last_bit) begin
          state_d   = ST_DONE;
          do_finish = 1'b1;
        end
      end
      ST_DONE: begin
        if (sen_off) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath and settings registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_q      <= CLK_IDLE;
      sen_q       <= ~SEN_IDLE;
      cfg_q       <= '0;
      cfg_act     <= '0;
      tx_hold     <= '0;
      tx_ready_q  <= 1'b1;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      tx_skip     <= 1'b0;
      readback_q  <= '0;
      rx_stb_q    <= 1'b0;
      abort_stb_q <= 1'b0;
    end else begin
      sclk_q      <= sclk_s;
      sen_q       <= sen_s;
      rx_stb_q    <= do_finish;
      abort_stb_q <= do_abort;

      if (do_finish) readback_q <= rx_shift_next;

      if (cfg_wr) begin
        cfg_q.num_bits <= set_data[CFG_NUM_BITS_LSB +: CFG_NUM_BITS_W];
        cfg_q.rx_edge  <= set_data[CFG_RX_EDGE_BIT];
        cfg_q.tx_edge  <= set_data[CFG_TX_EDGE_BIT];
      end

      if (do_select) begin
        cfg_act    <= cfg_q;
        tx_shift   <= tx_ready_q ? 32'd0 : tx_hold;
        tx_ready_q <= 1'b1;
        bit_cnt    <= '0;
        rx_shift   <= '0;
        tx_skip    <= (cfg_q.tx_edge == ~CLK_IDLE);
      end

      if (state_q == ST_SHIFT) begin
        if (rx_edge) begin
          rx_shift <= rx_shift_next;
          bit_cnt  <= bit_cnt_next;
        end
        if (tx_edge) begin
          if (tx_skip) tx_skip  <= 1'b0;
          else         tx_shift <= {tx_shift[30:0], 1'b0};
        end
      end

      // Placed after the select branch: a write landing on the select cycle
      // stays pending (tx_ready low) while the old word goes out.
      if (tx_wr) begin
        tx_hold    <= set_data;
        tx_ready_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign miso      = (state_q != ST_IDLE) ? tx_shift[31] : 1'b0;
  assign readback  = readback_q;
  assign rx_stb    = rx_stb_q;
  assign abort_stb = abort_stb_q;
  assign tx_ready  = tx_ready_q;
  assign debug     = {state_q, sen_s, sclk_s, mosi_s, miso, bit_cnt, 20'b0};

endmodule

// File: tb/tb_simple_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_simple_spi_slave
//   Directed bench for simple_spi_slave with default parameters
//   (BASE=0, CLK_IDLE=0, SEN_IDLE=1). A behavioural SPI master drives the pins
//   from the falling system-clock edge; expected words are hand-computed.
// -----------------------------------------------------------------------------
module tb_simple_spi_slave;

  localparam int HALF = 8;  // sclk half-period in system clocks

  logic        clock = 1'b0;
  logic        reset;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] readback;
  logic        rx_stb;
  logic        abort_stb;
  logic        tx_ready;
  logic        sen;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic [31:0] debug;

  int vectors     = 0;
  int miscompares = 0;

  int rx_stb_cnt  = 0;
  int abort_cnt   = 0;
  int both_cnt    = 0;
  int miso_hi_cnt = 0;

  simple_spi_slave dut (
    .clock     (clock),
    .reset     (reset),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .readback  (readback),
    .rx_stb    (rx_stb),
    .abort_stb (abort_stb),
    .tx_ready  (tx_ready),
    .sen       (sen),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .debug     (debug)
  );

  always #5 clock = ~clock;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clock) begin
    if (rx_stb)              rx_stb_cnt  <= rx_stb_cnt + 1;
    if (abort_stb)           abort_cnt   <= abort_cnt + 1;
    if (rx_stb && abort_stb) both_cnt    <= both_cnt + 1;
    if (miso)                miso_hi_cnt <= miso_hi_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = data;
    tick(1);
    set_stb  = 1'b0;
  endtask

  // One SPI frame from the master side. cpha=0: slave samples on rising,
  // master samples miso just before rising. cpha=1: master changes mosi on
  // rising, samples miso just before falling. glitch_at / reset_at insert a
  // 1-cycle sclk pulse or a 1-cycle reset at the start of that bit (cpha=0).
  task automatic spi_frame(input logic [31:0] word, input int nbits,
                           input bit cpha, input int glitch_at,
                           input int reset_at, output logic [31:0] got);
    got = '0;
    sen = 1'b0;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = word[nbits-1-i];
        if (i == reset_at) begin
          reset = 1'b1;
          tick(1);
          reset = 1'b0;
          tick(HALF - 1);
        end else if (i == glitch_at) begin
          tick(3);
          sclk = 1'b1;
          tick(1);
          sclk = 1'b0;
          tick(HALF - 4);
        end else begin
          tick(HALF);
        end
        got  = {got[30:0], miso};
        sclk = 1'b1;
        tick(HALF);
        sclk = 1'b0;
      end else begin
        sclk = 1'b1;
        mosi = word[nbits-1-i];
        tick(HALF);
        got  = {got[30:0], miso};
        sclk = 1'b0;
        tick(HALF);
      end
    end
    tick(HALF);
    sen = 1'b1;
    tick(10);
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    set_stb = 1'b0;
    set_addr = '0;
    set_data = '0;
    sen  = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    tick(3);
    vectors++;
    if (readback !== 32'h0) begin
      $display("FAIL reset_readback: got %h want %h", readback, 32'h0);
      miscompares++;
    end
    vectors++;
    if ({rx_stb, abort_stb, tx_ready, miso} !== 4'b0010) begin
      $display("FAIL reset_flags: got %b want %b", {rx_stb, abort_stb, tx_ready, miso}, 4'b0010);
      miscompares++;
    end
    vectors++;
    if (debug !== 32'h0) begin
      $display("FAIL reset_debug: got %h want %h", debug, 32'h0);
      miscompares++;
    end
    reset = 1'b0;
    tick(6);
    vectors++;
    if (debug !== 32'h2000_0000) begin
      $display("FAIL idle_debug: got %h want %h", debug, 32'h2000_0000);
      miscompares++;
    end
  endtask

  task automatic test_basic_frame;
    logic [31:0] got;
    int rx0, ab0;
    write_reg(8'd0, 32'h4000_0008);
    write_reg(8'd1, 32'hC300_0000);
    vectors++;
    if (tx_ready !== 1'b0) begin
      $display("FAIL txready_after_write: got %b want %b", tx_ready, 1'b0);
      miscompares++;
    end
    rx0 = rx_stb_cnt;
    ab0 = abort_cnt;
    spi_frame(32'hA5, 8, 1'b0, -1, -1, got);
    vectors++;
    if (readback !== 32'h0000_00A5) begin
      $display("FAIL basic_readback: got %h want %h", readback, 32'h0000_00A5);
      miscompares++;
    end
    vectors++;
    if (rx_stb_cnt - rx0 !== 1 || abort_cnt - ab0 !== 0) begin
      $display("FAIL basic_strobes: got rx=%0d abort=%0d want rx=1 abort=0",
               rx_stb_cnt - rx0, abort_cnt - ab0);
      miscompares++;
    end
    vectors++;
    if (got !== 32'h0000_00C3) begin
      $display("FAIL basic_miso_word: got %h want %h", got, 32'h0000_00C3);
      miscompares++;
    end
    vectors++;
    if (tx_ready !== 1'b1) begin
      $display("FAIL txready_after_frame: got %b want %b", tx_ready, 1'b1);
      miscompares++;
    end
  endtask

  task automatic test_32bit_leading;
    logic [31:0] got;
    int rx0;
    write_reg(8'd0, 32'h8000_0020);
    write_reg(8'd1, 32'hDEAD_BEEF);
    rx0 = rx_stb_cnt;
    spi_frame(32'hDEAD_BEEF, 32, 1'b1, -1, -1, got);
    vectors++;
    if (readback !== 32'hDEAD_BEEF) begin
      $display("FAIL w32_readback: got %h want %h", readback, 32'hDEAD_BEEF);
      miscompares++;
    end
    vectors++;
    if (got !== 32'hDEAD_BEEF) begin
      $display("FAIL w32_miso_word: got %h want %h", got, 32'hDEAD_BEEF);
      miscompares++;
    end
    vectors++;
    if (rx_stb_cnt - rx0 !== 1) begin
      $display("FAIL w32_rx_stb: got %0d want 1", rx_stb_cnt - rx0);
      miscompares++;
    end
  endtask

  task automatic test_abort;
    logic [31:0] got;
    int rx0, ab0;
    write_reg(8'd0, 32'h4000_0008);
    rx0 = rx_stb_cnt;
    ab0 = abort_cnt;
    spi_frame(32'h15, 5, 1'b0, -1, -1, got);
    vectors++;
    if (abort_cnt - ab0 !== 1 || rx_stb_cnt - rx0 !== 0) begin
      $display("FAIL abort_strobes: got abort=%0d rx=%0d want abort=1 rx=0",
               abort_cnt - ab0, rx_stb_cnt - rx0);
      miscompares++;
    end
    vectors++;
    if (readback !== 32'hDEAD_BEEF) begin
      $display("FAIL abort_readback: got %h want %h", readback, 32'hDEAD_BEEF);
      miscompares++;
    end
  endtask

  task automatic test_no_tx_write;
    logic [31:0] got;
    int rx0, mh0;
    rx0 = rx_stb_cnt;
    mh0 = miso_hi_cnt;
    spi_frame(32'h3C, 8, 1'b0, -1, -1, got);
    vectors++;
    if (readback !== 32'h0000_003C) begin
      $display("FAIL notx_readback: got %h want %h", readback, 32'h0000_003C);
      miscompares++;
    end
    vectors++;
    if (got !== 32'h0 || miso_hi_cnt - mh0 !== 0) begin
      $display("FAIL notx_miso: got word %h high_cycles %0d want 0 0", got, miso_hi_cnt - mh0);
      miscompares++;
    end
    vectors++;
    if (tx_ready !== 1'b1 || rx_stb_cnt - rx0 !== 1) begin
      $display("FAIL notx_status: got tx_ready=%b rx=%0d want 1 1", tx_ready, rx_stb_cnt - rx0);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] got;
    int rx0;
    write_reg(8'd0, 32'h4000_0008);
    write_reg(8'd1, 32'h8100_0000);
    rx0 = rx_stb_cnt;
    spi_frame(32'h66, 8, 1'b0, -1, 3, got);
    vectors++;
    if (rx_stb_cnt - rx0 !== 0 || readback !== 32'h0) begin
      $display("FAIL midreset_discard: got rx=%0d readback=%h want 0 0", rx_stb_cnt - rx0, readback);
      miscompares++;
    end
    write_reg(8'd0, 32'h4000_0008);
    write_reg(8'd1, 32'h8100_0000);
    rx0 = rx_stb_cnt;
    spi_frame(32'h7E, 8, 1'b0, -1, -1, got);
    vectors++;
    if (readback !== 32'h0000_007E || rx_stb_cnt - rx0 !== 1) begin
      $display("FAIL midreset_next: got readback=%h rx=%0d want 0000007e 1", readback, rx_stb_cnt - rx0);
      miscompares++;
    end
    vectors++;
    if (got !== 32'h0000_0081) begin
      $display("FAIL midreset_miso_word: got %h want %h", got, 32'h0000_0081);
      miscompares++;
    end
  endtask

  task automatic test_glitch;
    logic [31:0] got;
    logic [31:0] expect_rb;
    int rx0;
`ifdef SIMPLE_SPI_SLAVE_GLITCH_FILTER_EN
    expect_rb = 32'h0000_005A;  // pulse filtered, all 8 real bits counted
`else
    expect_rb = 32'h0000_005D;  // pulse counts as a bit: 0,1,0,1,1,1,0,1
`endif
    write_reg(8'd0, 32'h4000_0008);
    write_reg(8'd1, 32'hF000_0000);
    rx0 = rx_stb_cnt;
    spi_frame(32'h5A, 8, 1'b0, 4, -1, got);
    vectors++;
    if (readback !== expect_rb) begin
      $display("FAIL glitch_readback: got %h want %h", readback, expect_rb);
      miscompares++;
    end
    vectors++;
    if (rx_stb_cnt - rx0 !== 1) begin
      $display("FAIL glitch_rx_stb: got %0d want 1", rx_stb_cnt - rx0);
      miscompares++;
    end
    vectors++;
    if (got !== 32'h0000_00F0) begin
      $display("FAIL glitch_miso_word: got %h want %h", got, 32'h0000_00F0);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_32bit_leading();
    test_abort();
    test_no_tx_write();
    test_reset_mid_frame();
    test_glitch();
    vectors++;
    if (both_cnt !== 0) begin
      $display("FAIL strobe_overlap: got %0d cycles want 0", both_cnt);
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
